// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_bus_arbiter_pkg: shared arbiter state encoding and START/STOP line patterns
package i2c_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_UNKNOWN,
    ST_IDLE,
    ST_GRANTED,
    ST_EXT_BUSY
  } arb_state_t;
  // Patterns are {scl_q, scl, sda_q, sda}: SDA edge while SCL stays high
  localparam logic [3:0] START_PATTERN = 4'b1110;
  localparam logic [3:0] STOP_PATTERN  = 4'b1101;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: bus lines, requests and grant/status between arbiter and master engines
interface i2c_bus_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int IW = $clog2(NUM_REQ);
  logic               sclDebounced;
  logic               sdaDebounced;
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] releasePulse;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      ownerId;
  logic               busBusy;
  logic               startDetected;
  logic               stopDetected;
  logic               timeoutErr;
  modport master (
    input  sclDebounced, sdaDebounced, request, releasePulse,
    output grant, ownerId, busBusy, startDetected, stopDetected, timeoutErr
  );
  modport slave (
    output sclDebounced, sdaDebounced, request, releasePulse,
    input  grant, ownerId, busBusy, startDetected, stopDetected, timeoutErr
  );
endinterface

// File: rtl/i2c_bus_cond_detect.sv
// i2c_bus_cond_detect: line history, START/STOP detection and bus-free idle window
module i2c_bus_cond_detect
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int BUS_FREE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  input  logic hold,
  output logic start,
  output logic stop,
  output logic start_det,
  output logic stop_det,
  output logic free_ok
);
  localparam int FW = $clog2(BUS_FREE_CYCLES + 1);
  logic          scl_q;
  logic          sda_q;
  logic          hi;
  logic [FW-1:0] cnt;
  assign hi    = scl & sda;
  assign start = {scl_q, scl, sda_q, sda} == START_PATTERN;
  assign stop  = {scl_q, scl, sda_q, sda} == STOP_PATTERN;
  // free_ok looks ahead: it is true on the cycle that completes the idle window
  assign free_ok = hi && (cnt >= FW'(BUS_FREE_CYCLES - 1));
  // Line history, registered condition pulses and saturating idle counter (held clear while owned)
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      cnt       <= '0;
    end else begin
      scl_q     <= scl;
      sda_q     <= sda;
      start_det <= start;
      stop_det  <= stop;
      cnt       <= (hold || !hi) ? '0 : (cnt == FW'(BUS_FREE_CYCLES)) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin I2C bus ownership among local master engines
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int BUS_FREE_CYCLES = 64,
  parameter int START_TIMEOUT   = 1024
) (
  input logic              fastClock,
  input logic              reset,
  i2c_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [TW-1:0] tcnt;
  logic          started;
  logic          any_req;
  logic          own_drop;
  logic          start;
  logic          stop;
  logic          free_ok;
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction
  i2c_bus_cond_detect #(.BUS_FREE_CYCLES(BUS_FREE_CYCLES)) u_cond (
    .clk       (fastClock),
    .rst       (reset),
    .scl       (bus.sclDebounced),
    .sda       (bus.sdaDebounced),
    .hold      (state == ST_GRANTED),
    .start     (start),
    .stop      (stop),
    .start_det (bus.startDetected),
    .stop_det  (bus.stopDetected),
    .free_ok   (free_ok)
  );
  assign any_req  = |bus.request;
  assign own_drop = bus.releasePulse[bus.ownerId] | ~bus.request[bus.ownerId];
  // First set request at or after the pointer; scanning downwards lets the nearest one win
  always_comb begin
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.request[(int'(ptr) + i) % NUM_REQ]) pick = IW'((int'(ptr) + i) % NUM_REQ);
  end
  // Arbitration FSM with registered grant/status; a START cycle never changes the grant
  always_ff @(posedge fastClock) begin
    if (reset) begin
      state          <= ST_UNKNOWN;
      bus.grant      <= '0;
      bus.ownerId    <= '0;
      bus.busBusy    <= 1'b1;
      bus.timeoutErr <= 1'b0;
      ptr            <= '0;
      tcnt           <= '0;
      started        <= 1'b0;
    end else begin
      bus.timeoutErr <= 1'b0;
      case (state)
        ST_UNKNOWN:
          if (start) state <= ST_EXT_BUSY;
          else if (free_ok) begin
            state       <= ST_IDLE;
            bus.busBusy <= 1'b0;
          end
        ST_IDLE:
          if (start) begin
            state       <= ST_EXT_BUSY;
            bus.busBusy <= 1'b1;
          end else if (any_req) begin
            state       <= ST_GRANTED;
            bus.busBusy <= 1'b1;
            bus.grant   <= NUM_REQ'(1) << pick;
            bus.ownerId <= pick;
            tcnt        <= '0;
            started     <= 1'b0;
          end
        ST_GRANTED:
          if (start) started <= 1'b1;
          else if (own_drop || (!started && tcnt == TW'(START_TIMEOUT - 1))) begin
            state          <= ST_UNKNOWN;
            bus.grant      <= '0;
            bus.timeoutErr <= !own_drop;
            ptr            <= wrap_inc(bus.ownerId);
            tcnt           <= '0;
          end else if (!started) tcnt <= tcnt + 1'b1;
        ST_EXT_BUSY:
          if (stop) state <= ST_UNKNOWN;
        default: state <= ST_UNKNOWN;
      endcase
    end
  end
endmodule
